pid_controller: RTL and testbench
=================================

Name: pid_controller

Overview:
- Closed-loop motor control stage directly downstream of the serial command/status block.
- Consumes setpoint, gains, limits, deadband and control_mode from that block, plus encoder and displacement feedback.
- Produces the signed PWM duty command for the PWM generator; the same duty is reported back in the status frame.
- Runs one PID update per internal control tick, using one shared signed multiplier sequenced by an FSM.

Parameters:
CLK_FREQ_HZ, 16_000_000, system clock frequency
UPDATE_HZ, 1_000, control loop update rate
OUT_SHIFT, 0, arithmetic right shift applied to the PID sum before clamping

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-high
control_mode  in  8  0=position encoder0, 1=position encoder1, 2=displacement, 3=direct PWM, others=off
setpoint  in  24  signed target
encoder0_position  in  24  signed feedback
encoder1_position  in  24  signed feedback
displacement  in  24  signed feedback
Kp  in  24  signed gain
Ki  in  24  signed gain
Kd  in  24  signed gain
PWMLimit  in  24  unsigned duty magnitude limit
IntegralLimit  in  24  unsigned integrator magnitude limit
deadband  in  24  unsigned error deadband
duty  out  24  signed PWM command
update_done  out  1  one-cycle pulse when duty is refreshed

Behaviour:
- Reset (async, active-high; clock CLK): duty=0, update_done=0, integral=0, err_prev=0, tick counter=0, FSM=IDLE, mode_prev=0.
- Tick generator: counts 0..CLK_FREQ_HZ/UPDATE_HZ-1 and pulses tick for one cycle at wrap.
- FSM states: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SUM -> OUT -> IDLE; one cycle each.
- IDLE: leave on tick. A tick arriving while not in IDLE is dropped, never queued.
- ERR:
  - Selects feedback by mode.
  - err = setpoint - feedback, 25-bit signed.
  - If |err| <= deadband, err = 0.
  - If control_mode != mode_prev: integral=0, err_prev=0, mode_prev=control_mode.
- PTERM: acc = Kp*err (48-bit signed).
- ITERM:
  - integral = integral + err, clamped to [-IntegralLimit, +IntegralLimit]; the integrator is 32-bit signed internally.
  - acc += Ki*integral_new.
- DTERM: acc += Kd*(err - err_prev); then err_prev = err.
- SUM: acc_s = acc >>> OUT_SHIFT, then clamped to [-PWMLimit, +PWMLimit].
- OUT: duty <= clamped value; update_done = 1 for this cycle only.
- Latency: duty changes 7 cycles after the tick cycle.
- All inputs are sampled in ERR/PTERM/ITERM/DTERM as they stand. Upstream registers are stable between frames, so no extra capture is needed.
- Mode 3 (direct PWM): ERR jumps straight to SUM with acc = setpoint sign-extended; no shift is applied; clamp is still applied. Integral and err_prev are held at 0.
- Undefined modes: duty=0 on each update; integral and err_prev held at 0.
- PWMLimit=0 forces duty=0. IntegralLimit=0 forces integral=0.
- Multiplication is full signed 24x25 -> 48 bit; accumulation saturates at the 48-bit bounds and never wraps.
- Reset mid-update aborts the update immediately; duty returns to 0.

Decomposition:
- Shared package: control-mode constants (MODE_POS_ENC0, MODE_POS_ENC1, MODE_DISPLACEMENT, MODE_DIRECT_PWM), FSM state encoding, data widths (24/48).
- The status/command block imports the same mode constants.
- One sub-module: pid_tick_gen (parameterised divider emitting the one-cycle tick).
- The multiplier stays inline as a single shared operator.

Test Plan:
- Mode 0, Kp=10, Ki=Kd=0, setpoint=20, enc0=0, PWMLimit=500 -> duty=200 seven cycles after tick, with update_done pulse.
- Same, setpoint=100 -> raw sum 1000 clamps to duty=500; setpoint=-100 -> duty=-500.
- Deadband=5, Kp=10, err=4 -> duty=0; err=6 -> duty=60.
- Kp=0, Ki=1, IntegralLimit=50, constant err=10 -> duty 10,20,30,40,50,50 over successive ticks; switching to mode 1 clears the integrator, so the next duty uses integral=err only.
- Kp=Ki=0, Kd=2, err steps 0->10 -> duty=20 for one update, then 0.
- Mode 3, setpoint=-700, PWMLimit=500 -> duty=-500.
- Reset asserted during PTERM -> duty=0 at once, and the FSM returns to IDLE.

Source files
------------

// File: rtl/pid_controller_pkg.sv
// pid_controller_pkg
//   Shared definitions for the motor control stage: control-mode codes (also
//   used by the serial command/status block), FSM state encoding, data widths
//   and the 48-bit saturating helper used by the accumulator.
package pid_controller_pkg;

  localparam int DATA_W = 24;  // setpoint, feedback, gains, limits, duty
  localparam int ERR_W  = 25;  // setpoint - feedback
  localparam int INT_W  = 32;  // integrator
  localparam int ACC_W  = 48;  // PID accumulator

  localparam logic [7:0] MODE_POS_ENC0     = 8'd0;
  localparam logic [7:0] MODE_POS_ENC1     = 8'd1;
  localparam logic [7:0] MODE_DISPLACEMENT = 8'd2;
  localparam logic [7:0] MODE_DIRECT_PWM   = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_PTERM,
    ST_ITERM,
    ST_DTERM,
    ST_SUM,
    ST_OUT
  } pid_state_t;

  localparam logic signed [ACC_W+2:0] ACC_MAX_W = {3'b000, 1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+2:0] ACC_MIN_W = {3'b111, 1'b1, {(ACC_W-1){1'b0}}};

  // Clip a widened accumulator sum back into 48 bits without wrapping.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+2:0] x);
    if (x > ACC_MAX_W)      return ACC_MAX_W[ACC_W-1:0];
    else if (x < ACC_MIN_W) return ACC_MIN_W[ACC_W-1:0];
    else                    return x[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/pid_controller_tick_gen.sv
// pid_tick_gen
//   Free-running divider; tick is high for the single cycle in which the
//   counter sits at DIV-1, after which the counter wraps to 0.
//   Ports: CLK, reset (async, active-high), tick (one-cycle pulse).
module pid_tick_gen #(
  parameter int DIV = 16_000
) (
  input  logic CLK,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pid_controller.sv
// pid_controller
//   One PID update per control tick, sequenced through a single shared signed
//   multiplier: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SUM -> OUT.
//   Ports: CLK, reset (async, active-high), control_mode, setpoint,
//   encoder0_position, encoder1_position, displacement (signed feedback),
//   Kp/Ki/Kd (signed gains), PWMLimit/IntegralLimit/deadband (unsigned),
//   duty (signed PWM command), update_done (one-cycle pulse with new duty).
//
//   Handshake: there is none; upstream registers hold steady between frames,
//   duty is valid from reset on and update_done marks the first cycle in
//   which a refreshed duty is visible (no ready/back-pressure exists).
module pid_controller
  import pid_controller_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int UPDATE_HZ   = 1_000,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [7:0]               control_mode,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] encoder0_position,
  input  logic signed [DATA_W-1:0] encoder1_position,
  input  logic signed [DATA_W-1:0] displacement,
  input  logic signed [DATA_W-1:0] Kp,
  input  logic signed [DATA_W-1:0] Ki,
  input  logic signed [DATA_W-1:0] Kd,
  input  logic [DATA_W-1:0]        PWMLimit,
  input  logic [DATA_W-1:0]        IntegralLimit,
  input  logic [DATA_W-1:0]        deadband,
  output logic signed [DATA_W-1:0] duty,
  output logic                     update_done
);

  pid_state_t state, state_next;
  logic tick;

  logic signed [ERR_W-1:0]  err, err_prev;
  logic signed [INT_W-1:0]  integral;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] result;
  logic [7:0]               mode_prev;
  logic                     direct;  // acc already holds the final value; skip the shift

  pid_tick_gen #(.DIV(CLK_FREQ_HZ / UPDATE_HZ)) u_tick (
    .CLK   (CLK),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- error path ----------------
  logic signed [DATA_W-1:0] fb;
  logic signed [ERR_W-1:0]  err_raw, err_db;
  logic [ERR_W-1:0]         err_abs;
  logic                     pos_mode;

  assign pos_mode = (control_mode == MODE_POS_ENC0) || (control_mode == MODE_POS_ENC1) ||
                    (control_mode == MODE_DISPLACEMENT);

  always_comb begin
    fb = encoder0_position;
    if (control_mode == MODE_POS_ENC1)          fb = encoder1_position;
    else if (control_mode == MODE_DISPLACEMENT) fb = displacement;
  end

  assign err_raw = {setpoint[DATA_W-1], setpoint} - {fb[DATA_W-1], fb};
  assign err_abs = err_raw[ERR_W-1] ? -err_raw : err_raw;
  assign err_db  = (err_abs <= {1'b0, deadband}) ? '0 : err_raw;

  // ---------------- integrator ----------------
  logic signed [INT_W:0]   int_sum, il_pos, il_neg;
  logic signed [INT_W-1:0] integral_new;

  always_comb begin
    int_sum = {integral[INT_W-1], integral} + {{(INT_W+1-ERR_W){err[ERR_W-1]}}, err};
    il_pos  = {{(INT_W+1-DATA_W){1'b0}}, IntegralLimit};
    il_neg  = -il_pos;
    if (int_sum > il_pos)      integral_new = il_pos[INT_W-1:0];
    else if (int_sum < il_neg) integral_new = il_neg[INT_W-1:0];
    else                       integral_new = int_sum[INT_W-1:0];
  end

  // ---------------- shared multiplier ----------------
  // err - err_prev spans 26 bits, so the second operand is one bit wider
  // than the error itself; the widened product is folded back by sat_acc.
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [ERR_W:0]     mul_b, err_diff;
  logic signed [DATA_W+ERR_W:0] product;
  logic signed [ACC_W-1:0]   acc_in, acc_next;

  assign err_diff = {err[ERR_W-1], err} - {err_prev[ERR_W-1], err_prev};

  always_comb begin
    mul_a  = Kp;
    mul_b  = {err[ERR_W-1], err};
    acc_in = acc;
    case (state)
      ST_PTERM: acc_in = '0;
      ST_ITERM: begin
        mul_a = Ki;
        // IntegralLimit keeps the integrator within 25 signed bits.
        mul_b = integral_new[ERR_W:0];
      end
      ST_DTERM: begin
        mul_a = Kd;
        mul_b = err_diff;
      end
      default: ;
    endcase
  end

  assign product  = (DATA_W+ERR_W+1)'(mul_a) * (DATA_W+ERR_W+1)'(mul_b);
  assign acc_next = sat_acc((ACC_W+3)'(acc_in) + (ACC_W+3)'(product));

  // ---------------- output scaling and clamp ----------------
  // duty is 24-bit signed, so the usable magnitude tops out at 2^23-1 even
  // when PWMLimit asks for more.
  logic signed [ACC_W-1:0]  acc_s, lim_pos, lim_neg;
  logic [DATA_W-1:0]        lim;
  logic signed [DATA_W-1:0] clamped;

  always_comb begin
    acc_s   = direct ? acc : (acc >>> OUT_SHIFT);
    lim     = (PWMLimit > 24'h7FFFFF) ? 24'h7FFFFF : PWMLimit;
    lim_pos = {{(ACC_W-DATA_W){1'b0}}, lim};
    lim_neg = -lim_pos;
    if (acc_s > lim_pos)      clamped = lim;
    else if (acc_s < lim_neg) clamped = lim_neg[DATA_W-1:0];
    else                      clamped = acc_s[DATA_W-1:0];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (tick) state_next = ST_ERR;
      ST_ERR:   state_next = pos_mode ? ST_PTERM : ST_SUM;
      ST_PTERM: state_next = ST_ITERM;
      ST_ITERM: state_next = ST_DTERM;
      ST_DTERM: state_next = ST_SUM;
      ST_SUM:   state_next = ST_OUT;
      ST_OUT:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      duty        <= '0;
      update_done <= 1'b0;
      integral    <= '0;
      err_prev    <= '0;
      err         <= '0;
      acc         <= '0;
      result      <= '0;
      mode_prev   <= '0;
      direct      <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        ST_ERR: begin
          err    <= err_db;
          acc    <= '0;
          direct <= 1'b0;
          if (control_mode != mode_prev) begin
            integral  <= '0;
            err_prev  <= '0;
            mode_prev <= control_mode;
          end
          if (!pos_mode) begin
            // Direct PWM passes the setpoint through; unknown modes output 0.
            integral <= '0;
            err_prev <= '0;
            direct   <= 1'b1;
            if (control_mode == MODE_DIRECT_PWM)
              acc <= {{(ACC_W-DATA_W){setpoint[DATA_W-1]}}, setpoint};
          end
        end
        ST_PTERM: acc <= acc_next;
        ST_ITERM: begin
          integral <= integral_new;
          acc      <= acc_next;
        end
        ST_DTERM: begin
          acc      <= acc_next;
          err_prev <= err;
        end
        ST_SUM: result <= clamped;
        ST_OUT: begin
          duty        <= result;
          update_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller
//   Directed scenarios from the control-loop requirements plus randomized
//   updates checked against an arithmetic reference model of the PID rules.
module tb_pid_controller;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int UPDATE_HZ   = 50;     // 20 cycles per tick
  localparam int OUT_SHIFT   = 0;
  localparam int FIRST_LAT   = 26;     // tick at counter 19 -> ERR at edge 20 -> duty after edge 26

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic [7:0] control_mode = 8'd0;
  logic signed [23:0] setpoint = '0, enc0 = '0, enc1 = '0, displacement = '0;
  logic signed [23:0] Kp = '0, Ki = '0, Kd = '0;
  logic [23:0] PWMLimit = '0, IntegralLimit = '0, deadband = '0;
  logic signed [23:0] duty;
  logic update_done;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  // reference model state
  longint m_int = 0, m_prev = 0;
  logic [7:0] m_mode_prev = 8'd0;

  pid_controller #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .UPDATE_HZ(UPDATE_HZ), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .CLK(CLK), .reset(reset), .control_mode(control_mode), .setpoint(setpoint),
    .encoder0_position(enc0), .encoder1_position(enc1), .displacement(displacement),
    .Kp(Kp), .Ki(Ki), .Kd(Kd), .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
    .deadband(deadband), .duty(duty), .update_done(update_done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint sat48(input longint x);
    longint mx, mn;
    mx = (64'sd1 <<< 47) - 1;
    mn = -(64'sd1 <<< 47);
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

  function automatic longint model_step();
    longint fb, e, ae, acc, lim, il;
    if (control_mode != m_mode_prev) begin
      m_int = 0; m_prev = 0; m_mode_prev = control_mode;
    end
    if (control_mode <= 8'd2) begin
      fb = (control_mode == 8'd0) ? longint'(enc0) :
           (control_mode == 8'd1) ? longint'(enc1) : longint'(displacement);
      e  = longint'(setpoint) - fb;
      ae = (e < 0) ? -e : e;
      if (ae <= longint'(deadband)) e = 0;
      il  = longint'(IntegralLimit);
      acc = sat48(longint'(Kp) * e);
      m_int = m_int + e;
      if (m_int > il)  m_int = il;
      if (m_int < -il) m_int = -il;
      acc = sat48(acc + longint'(Ki) * m_int);
      acc = sat48(acc + longint'(Kd) * (e - m_prev));
      m_prev = e;
      acc = acc >>> OUT_SHIFT;
    end else if (control_mode == 8'd3) begin
      acc = longint'(setpoint); m_int = 0; m_prev = 0;
    end else begin
      acc = 0; m_int = 0; m_prev = 0;
    end
    lim = (longint'(PWMLimit) > 8388607) ? 8388607 : longint'(PWMLimit);
    if (acc > lim)  acc = lim;
    if (acc < -lim) acc = -lim;
    return acc;
  endfunction

  // ---------------- driver tasks ----------------
  // Steps the model for the next update with the inputs as they now stand,
  // waits for update_done and compares duty. Directed callers supply the
  // value worked out by hand; the model still runs to keep its state aligned.
  task automatic do_update(input string name, input bit use_const, input longint const_val);
    longint m;
    int n;
    m = model_step();
    exp_q.push_back(use_const ? 24'(const_val) : 24'(m));
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!update_done && n < 60);
    if (!update_done) begin
      checks++; errors++;
      $display("FAIL %s: no update_done within %0d cycles", name, n);
      void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (duty !== exp_q[0]) begin
      errors++;
      $display("FAIL %s: duty=%0d expected=%0d", name, duty, $signed(exp_q[0]));
    end
    void'(exp_q.pop_front());
    @(negedge CLK);
    checks++;
    if (update_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: update_done=%b expected=0", name, update_done);
    end
  endtask

  // Releases reset and checks the first update's latency and value.
  task automatic release_check(input string name, input longint exp_duty);
    int k;
    m_int = 0; m_prev = 0; m_mode_prev = 8'd0;
    void'(model_step());
    @(negedge CLK);
    reset = 1'b0;
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (!update_done && k < 60);
    checks++;
    if (k != FIRST_LAT) begin
      errors++;
      $display("FAIL %s_latency: cycles=%0d expected=%0d", name, k, FIRST_LAT);
    end
    checks++;
    if (duty !== 24'(exp_duty)) begin
      errors++;
      $display("FAIL %s_duty: duty=%0d expected=%0d", name, duty, exp_duty);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (update_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: update_done=%b expected=0", name, update_done);
    end
    @(negedge CLK);
  endtask

  task automatic set_basic(input logic [7:0] mode, input int sp, input int kp);
    control_mode = mode; setpoint = 24'(sp); Kp = 24'(kp);
    Ki = '0; Kd = '0; enc0 = '0; enc1 = '0; displacement = '0;
    PWMLimit = 24'd500; IntegralLimit = '0; deadband = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (duty !== 24'd0) begin
      errors++; $display("FAIL reset_duty: duty=%0d expected=0", duty);
    end
    checks++;
    if (update_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: update_done=%b expected=0", update_done);
    end
    set_basic(8'd0, 20, 10);
    release_check("first_update", 200);
  endtask

  task automatic test_proportional();
    setpoint = 24'sd100;  do_update("p_clamp_pos", 1, 500);
    setpoint = -24'sd100; do_update("p_clamp_neg", 1, -500);
    setpoint = 24'sd20;   do_update("p_plain", 1, 200);
  endtask

  task automatic test_deadband();
    deadband = 24'd5;
    setpoint = 24'sd4;  do_update("db_inside", 1, 0);
    setpoint = 24'sd6;  do_update("db_outside", 1, 60);
    setpoint = -24'sd6; do_update("db_outside_neg", 1, -60);
    setpoint = 24'sd5;  do_update("db_edge", 1, 0);
    deadband = '0;
  endtask

  task automatic test_integral();
    set_basic(8'd0, 10, 0);
    Ki = 24'sd1; IntegralLimit = 24'd50;
    for (int i = 1; i <= 6; i++)
      do_update($sformatf("int_step%0d", i), 1, (i * 10 > 50) ? 50 : i * 10);
    control_mode = 8'd1;
    do_update("int_mode_clear", 1, 10);
  endtask

  task automatic test_derivative();
    set_basic(8'd0, 0, 0);
    Kd = 24'sd2;
    do_update("d_zero", 1, 0);
    setpoint = 24'sd10; do_update("d_step", 1, 20);
    do_update("d_settle", 1, 0);
  endtask

  task automatic test_direct_and_off();
    set_basic(8'd3, -700, 0);
    do_update("direct_clamp", 1, -500);
    setpoint = 24'sd300; do_update("direct_pass", 1, 300);
    control_mode = 8'd9; do_update("undefined_mode", 1, 0);
  endtask

  task automatic test_zero_limits();
    set_basic(8'd0, 20, 10);
    PWMLimit = '0; do_update("pwm_limit_zero", 1, 0);
    set_basic(8'd0, 30, 0);
    Ki = 24'sd5; do_update("int_limit_zero", 1, 0);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) begin
        r = $urandom_range(0, 9);
        control_mode = (r <= 6) ? 8'(r % 3) : (r == 7) ? 8'd3 : 8'($urandom_range(4, 255));
      end
      if (i % 5 == 4) begin
        setpoint = 24'($urandom()); enc0 = 24'($urandom()); enc1 = 24'($urandom());
        displacement = 24'($urandom()); Kp = 24'($urandom()); Ki = 24'($urandom());
        Kd = 24'($urandom()); PWMLimit = 24'($urandom());
        IntegralLimit = 24'($urandom()); deadband = 24'($urandom_range(0, 1000));
      end else begin
        setpoint = 24'(int'($urandom_range(0, 200000)) - 100000);
        enc0 = 24'(int'($urandom_range(0, 200000)) - 100000);
        enc1 = 24'(int'($urandom_range(0, 200000)) - 100000);
        displacement = 24'(int'($urandom_range(0, 200000)) - 100000);
        Kp = 24'(int'($urandom_range(0, 2000)) - 1000);
        Ki = 24'(int'($urandom_range(0, 200)) - 100);
        Kd = 24'(int'($urandom_range(0, 2000)) - 1000);
        PWMLimit = 24'($urandom_range(0, 3000000));
        IntegralLimit = 24'($urandom_range(0, 5000));
        deadband = 24'($urandom_range(0, 200));
      end
      do_update($sformatf("random%0d", i), 0, 0);
    end
  endtask

  task automatic test_reset_mid_update();
    set_basic(8'd0, 20, 10);
    do_update("pre_abort", 1, 200);
    // Now one negedge past the duty edge; the next PTERM follows 14 edges on.
    repeat (14) @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (duty !== 24'd0) begin
      errors++; $display("FAIL abort_duty: duty=%0d expected=0", duty);
    end
    checks++;
    if (update_done !== 1'b0) begin
      errors++; $display("FAIL abort_done: update_done=%b expected=0", update_done);
    end
    repeat (3) @(negedge CLK);
    release_check("after_abort", 200);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_proportional();
    test_deadband();
    test_integral();
    test_derivative();
    test_direct_and_off();
    test_zero_limits();
    test_random();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
